wave_seq_ctrl: RTL
==================

Name: wave_seq_ctrl

Overview:
- Controller that sequences a three-signal test waveform (sig1, sig2, sig3) on a start/busy/done handshake.
- Latches a per-run config: toggle count and sig3 window. Runs the burst, then returns all outputs to idle levels.
- Sits between a test/config master and the waveform pins. Replaces free-running pattern counters with a bounded, restartable, abortable sequence.

Parameters:
CNT_W, 8, width of toggle count, window bounds and internal cycle counter.

Ports:
clk  in  1  single clock; posedge for FSM, counter, sig1, sig3; negedge for sig2 only.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  run request; sampled at posedge, honoured only in IDLE.
abort  in  1  terminates an active run; honoured only in RUN.
cfg_toggles  in  CNT_W  number of toggles N per run; valid range 1..2^CNT_W-1.
cfg_win_on  in  CNT_W  first toggle index k at which sig3 is high.
cfg_win_off  in  CNT_W  first toggle index k at which sig3 is low again.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse when a run completes normally.
cfg_err  out  1  one-cycle pulse when start is rejected.
sig1  out  1  posedge-toggled waveform; idle level 0.
sig2  out  1  negedge-toggled waveform; idle level 1.
sig3  out  1  window signal; idle level 0.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cnt=0, config regs=0. busy=0, done=0, cfg_err=0, sig1=0, sig2=1, sig3=0. These values apply immediately, including mid-run.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1 at edge E0:
  - Config is valid iff cfg_toggles!=0 and cfg_win_on<cfg_win_off.
  - Valid: latch cfg into internal regs, cnt<=0, state<=RUN.
  - Invalid: cfg_err=1 for the following cycle; state stays IDLE; nothing latched.
- RUN, edges E1..EN (N = latched toggles), with k = cnt after the edge:
  - Each edge: sig1 toggles; cnt<=cnt+1.
  - sig3 <= 1 iff win_on<=k<win_off and k<N; otherwise 0. win_on=0 behaves as 1. win_off>N is clipped at N.
  - At EN (cnt==N-1 before the edge): state<=DONE; sig3<=0.
- DONE: lasts exactly one cycle; done=1, busy=0.
  - At the next edge: state<=IDLE, sig1<=0.
- busy = (state==RUN), registered alongside the state. busy is high from E0+ through EN-.
- sig2 (negedge flop):
  - Toggles at each negedge where the registered state==RUN, giving N toggles, each half a cycle after the matching sig1 toggle.
  - Forced to 1 at any negedge where state==IDLE. Holds in DONE.
- abort=1 in RUN at any edge:
  - state<=IDLE, sig1<=0, sig3<=0, cnt<=0; no done pulse. sig2 returns to 1 at the next negedge.
  - abort takes priority over the EN completion at the same edge.
- Ignored inputs: start in RUN or DONE (no error flagged). abort outside RUN.
- start held high: at most one run per IDLE entry. A new run may be accepted on the DONE->IDLE edge + 1 cycle, i.e. the first IDLE cycle.
- Changes to cfg_* during a run have no effect; only latched values are used.
- Arithmetic: cnt is an unsigned CNT_W counter; it never wraps because N<=2^CNT_W-1. All comparisons are unsigned.

Decomposition:
- Package wave_seq_pkg: state enum (IDLE, RUN, DONE); CNT_W default; idle-level constants SIG1_IDLE=0, SIG2_IDLE=1, SIG3_IDLE=0.
- Sub-module wave_negedge_toggle: negedge sig2 flop with async rst_n, inputs run_en and force_idle.
- FSM, counter, sig1 and sig3 stay in the top level.

Test Plan:
- N=10, win_on=4, win_off=8, start pulse:
  - sig1 toggles at E1..E10 and ends 0; sig2 toggles 10 times at negedges, ends 1.
  - sig3 high for the 4 cycles after E4..E7; busy high for 10 cycles; done one pulse after E10; IDLE next.
- win_on=8, win_off=4, start: cfg_err pulses 1 cycle; busy, done and sigs stay 0/0/0,1,0. Repeat with toggles=0: same result.
- N=10, abort=1 at E3:
  - sig1=0 and sig3=0 after E3; sig2=1 at the next negedge.
  - No done pulse; a new start the next cycle is accepted.
- N=10, rst_n low between E5 and E6 (not on an edge): all outputs hit reset values without waiting for clk. After release, start runs a full 10-toggle burst.
- N=1, win_on=1, win_off=2, start held high continuously:
  - One sig1 toggle; sig3 never high (k<N fails).
  - done pulses, then a second run is accepted on the first IDLE cycle; starts during RUN/DONE ignored.
- N=255, win_on=250, win_off=255, with cfg_* changed mid-run:
  - Exactly 255 toggles; sig1 ends 1, then returns to 0 after DONE.
  - sig3 high after E250..E254; no counter wrap; latched cfg unaffected.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave sequencer: FSM state encoding,
// default counter width and the idle levels of the three waveform pins.
package wave_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic SIG1_IDLE = 1'b0;
  localparam logic SIG2_IDLE = 1'b1;
  localparam logic SIG3_IDLE = 1'b0;

endpackage

// File: rtl/wave_negedge_toggle.sv
// Falling-edge waveform flop: toggles while the sequencer runs, parks at
// its idle level whenever the sequencer is idle, holds otherwise.
module wave_negedge_toggle
  import wave_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run_en,
  input  logic force_idle,
  output logic sig_o
);

  logic sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (force_idle)  sig_d = SIG2_IDLE;
    else if (run_en) sig_d = ~sig_q;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SIG2_IDLE;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/wave_seq_ctrl.sv
// Bounded, abortable three-signal waveform sequencer with a start/busy/done
// handshake; the run configuration is latched when start is accepted.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_toggles,
  input  logic [CNT_W-1:0] cfg_win_on,
  input  logic [CNT_W-1:0] cfg_win_off,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             sig1,
  output logic             sig2,
  output logic             sig3
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] won_q, won_d;
  logic [CNT_W-1:0] woff_q, woff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sig1_q, sig1_d;
  logic             sig3_q, sig3_d;

  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] won_eff;
  logic             cfg_ok;
  logic             in_win;
  logic             last;

  assign cfg_ok  = (cfg_toggles != '0) && (cfg_win_on < cfg_win_off);
  // k is the toggle index after the current edge; the k<N term clips win_off at N
  assign k       = cnt_q + ONE;
  assign won_eff = (won_q == '0) ? ONE : won_q;
  assign in_win  = (k >= won_eff) && (k < woff_q) && (k < tog_q);
  assign last    = (cnt_q == tog_q - ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    won_d   = won_q;
    woff_d  = woff_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sig1_d  = sig1_q;
    sig3_d  = sig3_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            tog_d   = cfg_toggles;
            won_d   = cfg_win_on;
            woff_d  = cfg_win_off;
            cnt_d   = '0;
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // abort wins over completion on the same edge
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          sig1_d  = SIG1_IDLE;
          sig3_d  = SIG3_IDLE;
        end else begin
          sig1_d = ~sig1_q;
          cnt_d  = k;
          sig3_d = in_win;
          if (last) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sig3_d  = SIG3_IDLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        sig1_d  = SIG1_IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        sig1_d  = SIG1_IDLE;
        sig3_d  = SIG3_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      won_q   <= '0;
      woff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sig1_q  <= SIG1_IDLE;
      sig3_q  <= SIG3_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      won_q   <= won_d;
      woff_q  <= woff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sig1_q  <= sig1_d;
      sig3_q  <= sig3_d;
    end
  end

  wave_negedge_toggle u_sig2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (state_q == RUN),
    .force_idle (state_q == IDLE),
    .sig_o      (sig2)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = err_q;
  assign sig1    = sig1_q;
  assign sig3    = sig3_q;

endmodule
